// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sign-extender format codes, opcode fields and fetch FSM states.
// Used by the fetch stage and decode's control unit.
package cpu_pkg;

  localparam logic [1:0] SE_ITYPE  = 2'b00;
  localparam logic [1:0] SE_DTYPE  = 2'b01;
  localparam logic [1:0] SE_BTYPE  = 2'b10;
  localparam logic [1:0] SE_CBTYPE = 2'b11;

  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;
  // CBZ and CBNZ differ only in bit 24, so they share this 7-bit field.
  localparam logic [6:0]  OP_CBZ  = 7'b1011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DROP  = 2'd2
  } if_state_e;

  // Word offset to byte offset; the shift discards the top two offset bits, wrap is intended.
  function automatic logic [63:0] branch_target(input logic [63:0] base, input logic [63:0] word_off);
    return base + (word_off << 2);
  endfunction

endpackage

// File: rtl/ifetch_predecode.sv
// Combinational instruction-to-immediate-format decode, zero latency, no flow control.
module ifetch_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [1:0]  sext_ctrl
);

  always_comb begin
    sext_ctrl = SE_ITYPE;
    if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      sext_ctrl = SE_BTYPE;
    end else if (instr[31:25] == OP_CBZ) begin
      sext_ctrl = SE_CBTYPE;
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      sext_ctrl = SE_DTYPE;
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch into the IF/ID latch, one word per cycle on a zero-wait memory; optional IFETCH_STATS_EN counters.
// Stall parks one returned word in a skid register and drops the request; Redirect overrides Stall.
module ifetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [63:0] RedirectBase,
  input  logic [63:0] BusImm,
  output logic        IfIdValid,
  output logic [63:0] IfIdPC,
  output logic [31:0] IfIdInstr,
  output logic [25:0] Imm26,
  output logic [1:0]  SignExtCtrl
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  if_state_e   state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [63:0] drop_addr, drop_addr_nxt;
  logic [63:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_vld;

  logic        req;
  logic [63:0] addr;
  logic [63:0] target;
  logic        ifid_load, ifid_clr, from_skid;
  logic        skid_load, skid_clr;
  logic [63:0] load_pc;
  logic [31:0] load_instr;
  logic [1:0]  load_sext;

  assign target     = branch_target(RedirectBase, BusImm);
  assign load_pc    = from_skid ? skid_pc : pc;
  assign load_instr = from_skid ? skid_instr : IMemData;

  ifetch_predecode u_predecode (
    .instr     (load_instr),
    .sext_ctrl (load_sext)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    req           = 1'b0;
    addr          = pc;
    ifid_load     = 1'b0;
    ifid_clr      = 1'b0;
    from_skid     = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (Redirect) begin
          pc_nxt   = target;
          ifid_clr = 1'b1;
          skid_clr = 1'b1;
          // The address must not move under an unanswered request, so park it.
          if (!IMemReady) begin
            state_nxt     = DROP;
            drop_addr_nxt = pc;
          end
        end else if (IMemReady) begin
          pc_nxt = pc + 64'd4;
          if (Stall) begin
            skid_load = 1'b1;
            state_nxt = STALL;
          end else begin
            ifid_load = 1'b1;
          end
        end else if (!Stall) begin
          ifid_clr = 1'b1;
        end
      end
      STALL: begin
        if (Redirect) begin
          pc_nxt    = target;
          ifid_clr  = 1'b1;
          skid_clr  = 1'b1;
          state_nxt = FETCH;
        end else if (!Stall) begin
          ifid_load = 1'b1;
          from_skid = 1'b1;
          skid_clr  = 1'b1;
          state_nxt = FETCH;
        end
      end
      DROP: begin
        req      = 1'b1;
        addr     = drop_addr;
        ifid_clr = 1'b1;
        if (Redirect) begin
          pc_nxt   = target;
          skid_clr = 1'b1;
        end
        if (IMemReady) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Gated by reset directly so the request drops the moment reset asserts.
  assign IMemReq  = req & Reset_L;
  assign IMemAddr = IMemReq ? addr : 64'h0;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      drop_addr <= 64'h0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      skid_vld   <= 1'b0;
      skid_pc    <= 64'h0;
      skid_instr <= 32'h0;
    end else if (skid_clr) begin
      skid_vld <= 1'b0;
    end else if (skid_load) begin
      skid_vld   <= 1'b1;
      skid_pc    <= pc;
      skid_instr <= IMemData;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      IfIdValid   <= 1'b0;
      IfIdPC      <= 64'h0;
      IfIdInstr   <= 32'h0;
      Imm26       <= 26'h0;
      SignExtCtrl <= SE_ITYPE;
    end else if (ifid_clr) begin
      IfIdValid <= 1'b0;
    end else if (ifid_load) begin
      IfIdValid   <= from_skid ? skid_vld : 1'b1;
      IfIdPC      <= load_pc;
      IfIdInstr   <= load_instr;
      Imm26       <= load_instr[25:0];
      SignExtCtrl <= load_sext;
    end
  end

`ifdef IFETCH_STATS_EN
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      FetchCount  <= 32'h0;
      BubbleCount <= 32'h0;
    end else begin
      if (ifid_load && !ifid_clr && (!from_skid || skid_vld)) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (!IfIdValid) begin
        BubbleCount <= BubbleCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed self-checking bench for ifetch_stage; memory returns a PC-derived word unless a fixed word is forced.
module tb_ifetch_stage;

  logic        CLK;
  logic        Reset_L;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic        Stall;
  logic        Redirect;
  logic [63:0] RedirectBase;
  logic [63:0] BusImm;
  logic        IfIdValid;
  logic [63:0] IfIdPC;
  logic [31:0] IfIdInstr;
  logic [25:0] Imm26;
  logic [1:0]  SignExtCtrl;
`ifdef IFETCH_STATS_EN
  logic [31:0] FetchCount;
  logic [31:0] BubbleCount;
`endif

  int checks = 0;
  int errors = 0;

  logic        use_fixed;
  logic [31:0] fixed_word;

  ifetch_stage #(.RESET_PC(64'h100)) dut (
    .CLK          (CLK),
    .Reset_L      (Reset_L),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemReady    (IMemReady),
    .IMemData     (IMemData),
    .Stall        (Stall),
    .Redirect     (Redirect),
    .RedirectBase (RedirectBase),
    .BusImm       (BusImm),
    .IfIdValid    (IfIdValid),
    .IfIdPC       (IfIdPC),
    .IfIdInstr    (IfIdInstr),
    .Imm26        (Imm26),
    .SignExtCtrl  (SignExtCtrl)
`ifdef IFETCH_STATS_EN
    ,
    .FetchCount   (FetchCount),
    .BubbleCount  (BubbleCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'h9100_0000 | {20'h0, a[11:0]};
  endfunction

  always_comb IMemData = use_fixed ? fixed_word : word_at(IMemAddr);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    Reset_L = 1'b0; IMemReady = 1'b1; Stall = 1'b0; Redirect = 1'b0;
    RedirectBase = 64'h0; BusImm = 64'h0; use_fixed = 1'b0; fixed_word = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %0h want 0", IMemReq); end
    checks++; if (IMemAddr !== 64'h0) begin errors++; $display("FAIL rst_addr got %0h want 0", IMemAddr); end
    checks++; if (IfIdValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", IfIdValid); end
    checks++; if (IfIdPC !== 64'h0) begin errors++; $display("FAIL rst_pc got %0h want 0", IfIdPC); end
    checks++; if (IfIdInstr !== 32'h0) begin errors++; $display("FAIL rst_instr got %0h want 0", IfIdInstr); end
    checks++; if (Imm26 !== 26'h0) begin errors++; $display("FAIL rst_imm26 got %0h want 0", Imm26); end
    checks++; if (SignExtCtrl !== 2'b00) begin errors++; $display("FAIL rst_sext got %0h want 0", SignExtCtrl); end
    Reset_L = 1'b1;
    #1;
    checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL first_req got %0h want 1", IMemReq); end
    checks++; if (IMemAddr !== 64'h100) begin errors++; $display("FAIL addr0 got %0h want 100", IMemAddr); end
    tick();
    checks++; if (IMemAddr !== 64'h104) begin errors++; $display("FAIL addr1 got %0h want 104", IMemAddr); end
    checks++; if (IfIdValid !== 1'b1) begin errors++; $display("FAIL first_valid got %0h want 1", IfIdValid); end
    checks++; if (IfIdPC !== 64'h100) begin errors++; $display("FAIL first_pc got %0h want 100", IfIdPC); end
    checks++; if (IfIdInstr !== 32'h9100_0100) begin errors++; $display("FAIL first_instr got %0h want 91000100", IfIdInstr); end
    tick();
    checks++; if (IMemAddr !== 64'h108) begin errors++; $display("FAIL addr2 got %0h want 108", IMemAddr); end
    checks++; if (IfIdPC !== 64'h104) begin errors++; $display("FAIL second_pc got %0h want 104", IfIdPC); end
  endtask

  task automatic test_predecode();
    logic [31:0] words [4];
    logic [1:0]  sext  [4];
    logic [25:0] imm   [4];
    words[0] = 32'h1400_0003; sext[0] = 2'b10; imm[0] = 26'h000_0003;
    words[1] = 32'hB400_0041; sext[1] = 2'b11; imm[1] = 26'h000_0041;
    words[2] = 32'hF840_8020; sext[2] = 2'b01; imm[2] = 26'h040_8020;
    words[3] = 32'h9100_2820; sext[3] = 2'b00; imm[3] = 26'h100_2820;
    use_fixed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fixed_word = words[i];
      tick();
      checks++; if (IfIdInstr !== words[i]) begin errors++; $display("FAIL pd_instr%0d got %0h want %0h", i, IfIdInstr, words[i]); end
      checks++; if (SignExtCtrl !== sext[i]) begin errors++; $display("FAIL pd_sext%0d got %0h want %0h", i, SignExtCtrl, sext[i]); end
      checks++; if (Imm26 !== imm[i]) begin errors++; $display("FAIL pd_imm26_%0d got %0h want %0h", i, Imm26, imm[i]); end
    end
    use_fixed = 1'b0;
  endtask

  task automatic test_redirect();
    Redirect = 1'b1; RedirectBase = 64'h40; BusImm = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    Redirect = 1'b0;
    checks++; if (IMemAddr !== 64'h38) begin errors++; $display("FAIL redir_addr got %0h want 38", IMemAddr); end
    checks++; if (IfIdValid !== 1'b0) begin errors++; $display("FAIL redir_bubble got %0h want 0", IfIdValid); end
    tick();
    checks++; if (IfIdValid !== 1'b1) begin errors++; $display("FAIL redir_valid got %0h want 1", IfIdValid); end
    checks++; if (IfIdPC !== 64'h38) begin errors++; $display("FAIL redir_pc got %0h want 38", IfIdPC); end
    checks++; if (IMemAddr !== 64'h3C) begin errors++; $display("FAIL redir_next got %0h want 3c", IMemAddr); end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (IfIdPC !== 64'h38) begin errors++; $display("FAIL stall_pc%0d got %0h want 38", i, IfIdPC); end
      checks++; if (IfIdInstr !== 32'h9100_0038) begin errors++; $display("FAIL stall_instr%0d got %0h want 91000038", i, IfIdInstr); end
      checks++; if (IfIdValid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %0h want 1", i, IfIdValid); end
      checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %0h want 0", i, IMemReq); end
    end
    Stall = 1'b0;
    tick();
    checks++; if (IfIdPC !== 64'h3C) begin errors++; $display("FAIL skid_pc got %0h want 3c", IfIdPC); end
    checks++; if (IfIdInstr !== 32'h9100_003C) begin errors++; $display("FAIL skid_instr got %0h want 9100003c", IfIdInstr); end
    checks++; if (IfIdValid !== 1'b1) begin errors++; $display("FAIL skid_valid got %0h want 1", IfIdValid); end
    checks++; if (IMemAddr !== 64'h40) begin errors++; $display("FAIL resume_addr got %0h want 40", IMemAddr); end
    tick();
    checks++; if (IfIdPC !== 64'h40) begin errors++; $display("FAIL after_skid_pc got %0h want 40", IfIdPC); end
    checks++; if (IMemAddr !== 64'h44) begin errors++; $display("FAIL after_skid_addr got %0h want 44", IMemAddr); end
  endtask

  task automatic test_latency_redirect();
    IMemReady = 1'b0;
    tick();
    checks++; if (IMemAddr !== 64'h44) begin errors++; $display("FAIL lat_hold1 got %0h want 44", IMemAddr); end
    Redirect = 1'b1; RedirectBase = 64'h200; BusImm = 64'h4;
    tick();
    Redirect = 1'b0;
    checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL drop_req got %0h want 1", IMemReq); end
    checks++; if (IMemAddr !== 64'h44) begin errors++; $display("FAIL lat_hold2 got %0h want 44", IMemAddr); end
    checks++; if (IfIdValid !== 1'b0) begin errors++; $display("FAIL drop_valid got %0h want 0", IfIdValid); end
    IMemReady = 1'b1;
    tick();
    checks++; if (IfIdValid !== 1'b0) begin errors++; $display("FAIL drop_discard got %0h want 0", IfIdValid); end
    checks++; if (IMemAddr !== 64'h210) begin errors++; $display("FAIL lat_target got %0h want 210", IMemAddr); end
    tick();
    checks++; if (IfIdPC !== 64'h210) begin errors++; $display("FAIL lat_pc got %0h want 210", IfIdPC); end
    checks++; if (IfIdInstr !== 32'h9100_0210) begin errors++; $display("FAIL lat_instr got %0h want 91000210", IfIdInstr); end
    checks++; if (IfIdValid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0h want 1", IfIdValid); end
  endtask

`ifdef IFETCH_STATS_EN
  task automatic test_stats();
    apply_reset();
    Reset_L = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (FetchCount !== 32'd10) begin errors++; $display("FAIL stats_fetch10 got %0d want 10", FetchCount); end
    checks++; if (BubbleCount !== 32'd1) begin errors++; $display("FAIL stats_bubble1 got %0d want 1", BubbleCount); end
    Redirect = 1'b1; RedirectBase = 64'h0; BusImm = 64'h0;
    tick();
    tick();
    Redirect = 1'b0; IMemReady = 1'b0;
    tick();
    checks++; if (FetchCount !== 32'd10) begin errors++; $display("FAIL stats_fetch got %0d want 10", FetchCount); end
    checks++; if (BubbleCount !== 32'd3) begin errors++; $display("FAIL stats_bubble got %0d want 3", BubbleCount); end
  endtask
`endif

  initial begin
    test_reset();
    test_predecode();
    test_redirect();
    test_stall();
    test_latency_redirect();
`ifdef IFETCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
